// File: rtl/fp_mul_pkg.sv
// fp32 field layout, result-class flag indices and a classifier shared by the stream multiplier front-end.
package fp_mul_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MANT_MSB = 22;
    localparam int FP_MANT_LSB = 0;

    localparam logic [FP_EXP_MSB-FP_EXP_LSB:0] EXP_ALL_ONES = 8'hFF;

    localparam int FLAG_SUBNORMAL = 0;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_INF       = 2;
    localparam int FLAG_NAN       = 3;
    localparam int FLAG_W         = 4;

    typedef logic [FP_SIGN_BIT:0] fp32_t;

    // Returns {nan, inf, zero, subnormal}; the sign bit plays no part in the class.
    function automatic logic [FLAG_W-1:0] fp32_classify(input fp32_t v);
        logic [FP_EXP_MSB-FP_EXP_LSB:0] w_exp;
        logic [FP_MANT_MSB:FP_MANT_LSB] w_mant;
        logic [FLAG_W-1:0]              w_flags;
        w_exp   = v[FP_EXP_MSB:FP_EXP_LSB];
        w_mant  = v[FP_MANT_MSB:FP_MANT_LSB];
        w_flags = '0;
        w_flags[FLAG_NAN]       = (w_exp == EXP_ALL_ONES) && (w_mant != '0);
        w_flags[FLAG_INF]       = (w_exp == EXP_ALL_ONES) && (w_mant == '0);
        w_flags[FLAG_ZERO]      = (w_exp == '0) && (w_mant == '0);
        w_flags[FLAG_SUBNORMAL] = (w_exp == '0) && (w_mant != '0);
        return w_flags;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on o_rd_data whenever o_empty is low.
module fp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_full;
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra wrap bit on each pointer distinguishes full from empty when the addresses match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_wr   = i_wr_en && !w_full;
    assign w_do_rd   = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(i_wr_en && w_full));

endmodule

// File: rtl/fp_mul_stream.sv
// Valid/ready front-end for a fixed-latency fp32 multiplier core with a credit-guarded result FIFO.
// Optional macro FP_MUL_RESULT_FLAGS_EN adds out_flags {nan, inf, zero, subnormal} per result.
module fp_mul_stream
    import fp_mul_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mul_areset,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [DATA_W-1:0] mul_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_q,
`ifdef FP_MUL_RESULT_FLAGS_EN
    output logic [FLAG_W-1:0] out_flags,
`endif
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
`ifdef FP_MUL_RESULT_FLAGS_EN
    localparam int ENTRY_W = DATA_W + FLAG_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic               r_mul_areset;
    logic               r_init_done;
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic [MUL_LAT:0]   r_tag;
    logic               w_accept;
    logic               w_capture;
    logic               w_pop;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [SUM_W-1:0]   w_inflight;
    logic [SUM_W-1:0]   w_used;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;

    // Core reset trails rst by one edge; acceptance opens one edge after the core leaves reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mul_areset <= 1'b1;
            r_init_done  <= 1'b0;
        end else begin
            r_mul_areset <= 1'b0;
            r_init_done  <= ~r_mul_areset;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_tag   <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
            end
            r_tag <= {r_tag[MUL_LAT-1:0], w_accept};
        end
    end

    // Every accepted pair reserves a FIFO slot until it is popped, so a capture never finds the FIFO full.
    assign w_inflight = SUM_W'($countones(r_tag));
    assign w_used     = SUM_W'(w_fifo_count) + w_inflight;
    assign in_ready   = r_init_done && (w_used < SUM_W'(FIFO_DEPTH));
    assign w_accept   = in_valid && in_ready;
    assign w_capture  = r_tag[MUL_LAT];
    assign out_valid  = ~w_fifo_empty;
    assign w_pop      = out_valid && out_ready;
    assign busy       = (|r_tag) || !w_fifo_empty;

    assign mul_areset = r_mul_areset;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;

`ifdef FP_MUL_RESULT_FLAGS_EN
    assign w_wr_entry = {fp32_classify(fp32_t'(mul_q)), mul_q};
    assign out_flags  = w_fifo_empty ? '0 : w_rd_entry[ENTRY_W-1:DATA_W];
`else
    assign w_wr_entry = mul_q;
`endif
    assign out_q      = w_fifo_empty ? '0 : w_rd_entry[DATA_W-1:0];

    fp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_capture),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_entry),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

endmodule

// File: tb/tb_fp_mul_stream.sv
// Scoreboard bench for fp_mul_stream: behavioural fp32 core model, randomized stream, negedge monitor.
module tb_fp_mul_stream;
    localparam int DATA_W     = 32;
    localparam int MUL_LAT    = 3;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_areset;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic        busy;
`ifdef FP_MUL_RESULT_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    fp_mul_stream #(
        .DATA_W     (DATA_W),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_areset (mul_areset),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_q      (mul_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
`ifdef FP_MUL_RESULT_FLAGS_EN
        .out_flags  (out_flags),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    // IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e;
        logic [22:0] fa, fb;
        logic [47:0] p;
        logic [24:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
            return 32'h7FC0_0000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {s, 31'd0};
        p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        e = ea + eb - 127;
        if (p[47]) e = e + 1;
        else p = p << 1;
        m = {1'b0, p[47:24]};
        if (p[23] && ((|p[22:0]) || p[24])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m[22:0]};
    endfunction

`ifdef FP_MUL_RESULT_FLAGS_EN
    function automatic logic [3:0] classify(input logic [31:0] v);
        logic [31:0] mag;
        mag = v & 32'h7FFF_FFFF;
        return {mag > 32'h7F80_0000, mag == 32'h7F80_0000, mag == 32'h0, (mag != 0) && (mag < 32'h0080_0000)};
    endfunction
`endif

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r = 32'h0000_0000;
            1:       r = 32'h7F80_0000;
            2:       r = 32'h7FC0_0000;
            3:       r = {r[31], 8'h00, r[22:0]};
            4:       r = {r[31], 8'hFE, r[22:0]};
            5, 6:    ;
            default: r = {r[31], 8'($urandom_range(100, 154)), r[22:0]};
        endcase
        return r;
    endfunction

    // Fixed-latency core: q is the product of the operands presented MUL_LAT cycles earlier.
    logic [31:0] core_pipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_areset) begin
            for (int i = 0; i < MUL_LAT; i++) core_pipe[i] <= 32'h0;
        end else begin
            core_pipe[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < MUL_LAT; i++) core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign mul_q = core_pipe[MUL_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard: accepted pairs push their product; every pop is compared against the head.
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic        stall_valid = 1'b0;
    logic [31:0] stall_q     = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            stall_valid <= 1'b0;
        end else begin
            if (stall_valid) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_q", out_q, stall_q);
            end
            if (out_valid && exp_q.size() == 0) begin
                chk1("spurious_out_valid", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                exp_v = exp_q.pop_front();
                chk("out_q", out_q, exp_v);
`ifdef FP_MUL_RESULT_FLAGS_EN
                chk("out_flags", 32'(out_flags), 32'(classify(exp_v)));
`endif
                n_out++;
                $display("[cycle %0d] result %0d: q=%h", cyc, n_out, out_q);
            end
            if (in_valid && in_ready) exp_q.push_back(fmul(in_a, in_b));
            stall_valid <= out_valid && !out_ready;
            stall_q     <= out_q;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk1("send_timeout", in_ready, 1'b1);
        acc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 500);
        chk1("drain_busy", busy, 1'b0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc, n, acc;
        logic [31:0] b2b_exp [3];
        b2b_exp[0] = 32'h41C0_0000;
        b2b_exp[1] = 32'h41A0_0000;
        b2b_exp[2] = 32'h41F0_0000;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;

        // Reset release sequence
        repeat (2) begin
            @(negedge clk);
            chk1("rst_areset", mul_areset, 1'b1);
            chk1("rst_in_ready", in_ready, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("areset_before_edge", mul_areset, 1'b1);
        @(negedge clk);
        chk1("areset_released", mul_areset, 1'b0);
        chk1("in_ready_early", in_ready, 1'b0);
        chk1("out_valid_idle", out_valid, 1'b0);
        @(negedge clk);
        chk1("in_ready_up", in_ready, 1'b1);
        chk1("out_valid_idle2", out_valid, 1'b0);
        tick();

        // Single pair latency
        out_ready = 1'b1;
        send(32'h3F80_0000, 32'h3F80_0000, acc_cyc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("single_latency", cyc - acc_cyc, 32'd5);
        chk("single_q", out_q, 32'h3F80_0000);
        tick();

        // Back-to-back with out_ready high
        send(32'h4000_0000, 32'h4140_0000, acc);
        send(32'h4080_0000, 32'h40A0_0000, acc);
        send(32'h40A0_0000, 32'h40C0_0000, acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        for (int i = 0; i < 3; i++) begin
            chk1("b2b_valid", out_valid, 1'b1);
            chk("b2b_q", out_q, b2b_exp[i]);
            @(negedge clk);
        end
        chk1("b2b_end", out_valid, 1'b0);
        tick();

        // Full-rate stream with consumer always ready
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            in_a = rand_op();
            in_b = rand_op();
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("full_rate_accepts", 32'(acc), 32'd40);
        wait_drain();

        // Backpressure: credits stop acceptance at FIFO_DEPTH outstanding
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_a = rand_op();
            in_b = rand_op();
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd8);
        @(negedge clk);
        chk1("bp_in_ready", in_ready, 1'b0);
        chk1("bp_busy", busy, 1'b1);
        chk1("bp_out_valid", out_valid, 1'b1);
        tick();
        out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk1("bp_in_ready_back", in_ready, 1'b1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rand_op();
            in_b      = rand_op();
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset with 2 buffered and 3 in flight
        out_ready = 1'b0;
        send(rand_op(), rand_op(), acc);
        send(rand_op(), rand_op(), acc);
        repeat (8) tick();
        send(rand_op(), rand_op(), acc);
        send(rand_op(), rand_op(), acc);
        send(rand_op(), rand_op(), acc);
        chk1("pre_rst_busy", busy, 1'b1);
        chk1("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk1("post_rst_out_valid", out_valid, 1'b0);
            chk1("post_rst_busy", busy, 1'b0);
        end
        tick();

`ifdef FP_MUL_RESULT_FLAGS_EN
        // Special-value classes through the flag path
        send(32'h7F80_0000, 32'h0000_0000, acc);
        send(32'h7F00_0000, 32'h4000_0000, acc);
        wait_drain();
`endif

        // A short stream after the mid-flight reset proves nothing stale survived
        for (int i = 0; i < 10; i++) send(rand_op(), rand_op(), acc);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
